// File: rtl/vector_rf_wb_arbiter_pkg.sv
// Shared codes for the vector register-file write-back scheduler:
// RF command encodings, element data types, requester IDs and FSM states.
package vector_rf_wb_arbiter_pkg;

   localparam int VREG_IDX_W = 5;

   localparam logic [1:0] RF_NOP          = 2'b00;
   localparam logic [1:0] VECTOR_RF_WRITE = 2'b10;

   localparam logic [2:0] ONE_BYTE  = 3'd0;
   localparam logic [2:0] TWO_BYTE  = 3'd1;
   localparam logic [2:0] FOUR_BYTE = 3'd2;
   localparam logic [2:0] ONE_BIT   = 3'd3;

   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_LSU = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } wb_state_e;

endpackage

// File: rtl/vector_rr_arb2.sv
// Two-way round-robin grant between the ALU and LSU write-back requesters.
// The previous winner is supplied by the caller, so this block is purely combinational.
module vector_rr_arb2
   import vector_rf_wb_arbiter_pkg::*;
(
   input  logic req_alu_i,
   input  logic req_lsu_i,
   input  logic last_grant_i,
   output logic gnt_valid_o,
   output logic gnt_id_o
);

   // On contention the requester that did not win last time goes first.
   always_comb begin
      gnt_valid_o = req_alu_i | req_lsu_i;
      gnt_id_o    = REQ_ALU;
      if (req_alu_i && req_lsu_i) begin
         gnt_id_o = ~last_grant_i;
      end else if (req_lsu_i) begin
         gnt_id_o = REQ_LSU;
      end
   end

endmodule

// File: rtl/vector_rf_wb_arbiter.sv
// Single-write-port scheduler for the vector register file: arbitrates ALU/LSU
// write-backs, drives one RF write per grant, and tracks pending writes for issue hazards.
module vector_rf_wb_arbiter
   import vector_rf_wb_arbiter_pkg::*;
#(
   parameter int VECTOR_SIZE = 8,
   parameter int DATA_LEN    = 32,
   parameter int NUM_VREG    = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rdy_in,
   input  logic                            issue_valid,
   output logic                            issue_ready,
   input  logic [VREG_IDX_W-1:0]           issue_rs1,
   input  logic [VREG_IDX_W-1:0]           issue_rs2,
   input  logic [VREG_IDX_W-1:0]           issue_rs3,
   input  logic [VREG_IDX_W-1:0]           issue_rd,
   input  logic                            issue_use_rs1,
   input  logic                            issue_use_rs2,
   input  logic                            issue_use_rs3,
   input  logic                            issue_wr_rd,
   input  logic                            alu_wb_valid,
   output logic                            alu_wb_ready,
   input  logic [VREG_IDX_W-1:0]           alu_wb_rd,
   input  logic [VECTOR_SIZE*DATA_LEN-1:0] alu_wb_data,
   input  logic [VECTOR_SIZE*DATA_LEN-1:0] alu_wb_mask,
   input  logic                            alu_wb_vm,
   input  logic [DATA_LEN-1:0]             alu_wb_length,
   input  logic [2:0]                      alu_wb_dtype,
   input  logic                            lsu_wb_valid,
   output logic                            lsu_wb_ready,
   input  logic [VREG_IDX_W-1:0]           lsu_wb_rd,
   input  logic [VECTOR_SIZE*DATA_LEN-1:0] lsu_wb_data,
   input  logic [VECTOR_SIZE*DATA_LEN-1:0] lsu_wb_mask,
   input  logic                            lsu_wb_vm,
   input  logic [DATA_LEN-1:0]             lsu_wb_length,
   input  logic [2:0]                      lsu_wb_dtype,
   output logic [1:0]                      rf_signal,
   output logic [VREG_IDX_W-1:0]           rf_rd,
   output logic [VECTOR_SIZE*DATA_LEN-1:0] rf_data,
   output logic [VECTOR_SIZE*DATA_LEN-1:0] rf_mask,
   output logic                            rf_vm,
   output logic [DATA_LEN-1:0]             rf_length,
   output logic [2:0]                      rf_dtype,
   output logic                            rf_wb_en,
   output logic [NUM_VREG-1:0]             busy_vec,
   output logic                            wb_err
);

   localparam int VW = VECTOR_SIZE * DATA_LEN;

   wb_state_e             state_q, state_d;
   logic [NUM_VREG-1:0]   busy_q, busy_d;
   logic                  last_grant_q, last_grant_d;
   logic                  err_q, err_d;
   logic                  rf_wb_en_q, rf_wb_en_d;
   logic [1:0]            rf_signal_q, rf_signal_d;
   logic [VREG_IDX_W-1:0] rf_rd_q, rf_rd_d;
   logic [VW-1:0]         rf_data_q, rf_data_d;
   logic [VW-1:0]         rf_mask_q, rf_mask_d;
   logic                  rf_vm_q, rf_vm_d;
   logic [DATA_LEN-1:0]   rf_length_q, rf_length_d;
   logic [2:0]            rf_dtype_q, rf_dtype_d;

   logic gnt_valid;
   logic gnt_id;
   logic accept;
   logic commit;
   logic hazard;
   logic issue_fire;

   vector_rr_arb2 u_arb (
      .req_alu_i    (alu_wb_valid),
      .req_lsu_i    (lsu_wb_valid),
      .last_grant_i (last_grant_q),
      .gnt_valid_o  (gnt_valid),
      .gnt_id_o     (gnt_id)
   );

   // Hazards use the registered scoreboard only, so a register cleared this
   // cycle still stalls its consumer until the next one.
   assign hazard = (issue_use_rs1 & busy_q[issue_rs1]) |
                   (issue_use_rs2 & busy_q[issue_rs2]) |
                   (issue_use_rs3 & busy_q[issue_rs3]) |
                   (issue_wr_rd   & busy_q[issue_rd]);
   assign issue_ready = rdy_in & ~hazard;
   assign issue_fire  = issue_valid & issue_ready & issue_wr_rd;

   assign accept       = rdy_in & (state_q == ST_IDLE) & gnt_valid;
   assign commit       = rdy_in & (state_q == ST_WRITE);
   assign alu_wb_ready = accept & (gnt_id == REQ_ALU);
   assign lsu_wb_ready = accept & (gnt_id == REQ_LSU);

   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      last_grant_d = last_grant_q;
      err_d        = err_q;
      rf_wb_en_d   = rf_wb_en_q;
      rf_signal_d  = rf_signal_q;
      rf_rd_d      = rf_rd_q;
      rf_data_d    = rf_data_q;
      rf_mask_d    = rf_mask_q;
      rf_vm_d      = rf_vm_q;
      rf_length_d  = rf_length_q;
      rf_dtype_d   = rf_dtype_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d      = ST_WRITE;
               last_grant_d = gnt_id;
               rf_wb_en_d   = 1'b1;
               rf_signal_d  = VECTOR_RF_WRITE;
               if (gnt_id == REQ_ALU) begin
                  rf_rd_d     = alu_wb_rd;
                  rf_data_d   = alu_wb_data;
                  rf_mask_d   = alu_wb_mask;
                  rf_vm_d     = alu_wb_vm;
                  rf_length_d = alu_wb_length;
                  rf_dtype_d  = alu_wb_dtype;
               end else begin
                  rf_rd_d     = lsu_wb_rd;
                  rf_data_d   = lsu_wb_data;
                  rf_mask_d   = lsu_wb_mask;
                  rf_vm_d     = lsu_wb_vm;
                  rf_length_d = lsu_wb_length;
                  rf_dtype_d  = lsu_wb_dtype;
               end
            end
         end
         ST_WRITE: begin
            if (commit) begin
               state_d     = ST_IDLE;
               rf_wb_en_d  = 1'b0;
               rf_signal_d = RF_NOP;
               err_d       = err_q | ~busy_q[rf_rd_q];
               busy_d[rf_rd_q] = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Issue never targets a busy register, so this set cannot collide with the clear above.
      if (issue_fire) begin
         busy_d[issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         busy_q       <= '0;
         last_grant_q <= REQ_LSU;
         err_q        <= 1'b0;
         rf_wb_en_q   <= 1'b0;
         rf_signal_q  <= RF_NOP;
         rf_rd_q      <= '0;
         rf_data_q    <= '0;
         rf_mask_q    <= '0;
         rf_vm_q      <= 1'b0;
         rf_length_q  <= '0;
         rf_dtype_q   <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         last_grant_q <= last_grant_d;
         err_q        <= err_d;
         rf_wb_en_q   <= rf_wb_en_d;
         rf_signal_q  <= rf_signal_d;
         rf_rd_q      <= rf_rd_d;
         rf_data_q    <= rf_data_d;
         rf_mask_q    <= rf_mask_d;
         rf_vm_q      <= rf_vm_d;
         rf_length_q  <= rf_length_d;
         rf_dtype_q   <= rf_dtype_d;
      end
   end

   assign busy_vec  = busy_q;
   assign wb_err    = err_q;
   assign rf_wb_en  = rf_wb_en_q;
   assign rf_signal = rf_signal_q;
   assign rf_rd     = rf_rd_q;
   assign rf_data   = rf_data_q;
   assign rf_mask   = rf_mask_q;
   assign rf_vm     = rf_vm_q;
   assign rf_length = rf_length_q;
   assign rf_dtype  = rf_dtype_q;

endmodule

// File: tb/tb_vector_rf_wb_arbiter.sv
// Self-checking bench for vector_rf_wb_arbiter: hazard table plus hand sequences
// for arbitration, stalls, error flag and reset; RF writes are scoreboarded.
module tb_vector_rf_wb_arbiter;
   import vector_rf_wb_arbiter_pkg::*;

   localparam int VS = 8;
   localparam int DL = 32;
   localparam int NV = 32;
   localparam int VW = VS * DL;

   logic          clk = 1'b0;
   logic          rst;
   logic          rdy_in;
   logic          issue_valid;
   logic          issue_ready;
   logic [4:0]    issue_rs1, issue_rs2, issue_rs3, issue_rd;
   logic          issue_use_rs1, issue_use_rs2, issue_use_rs3, issue_wr_rd;
   logic          alu_wb_valid, alu_wb_ready, lsu_wb_valid, lsu_wb_ready;
   logic [4:0]    alu_wb_rd, lsu_wb_rd;
   logic [VW-1:0] alu_wb_data, alu_wb_mask, lsu_wb_data, lsu_wb_mask;
   logic          alu_wb_vm, lsu_wb_vm;
   logic [DL-1:0] alu_wb_length, lsu_wb_length;
   logic [2:0]    alu_wb_dtype, lsu_wb_dtype;
   logic [1:0]    rf_signal;
   logic [4:0]    rf_rd;
   logic [VW-1:0] rf_data, rf_mask;
   logic          rf_vm;
   logic [DL-1:0] rf_length;
   logic [2:0]    rf_dtype;
   logic          rf_wb_en;
   logic [NV-1:0] busy_vec;
   logic          wb_err;

   typedef struct {
      logic [4:0]    rd;
      logic [VW-1:0] data;
      logic [VW-1:0] mask;
      logic          vm;
      logic [DL-1:0] len;
      logic [2:0]    dtype;
   } wb_t;

   typedef struct {
      logic [4:0] rs1, rs2, rs3, rd;
      logic       u1, u2, u3, wr, rdy, exp;
   } hz_t;

   wb_t sbq[$];
   wb_t sbPush;
   wb_t sbExp;
   int  total   = 0;
   int  bad     = 0;
   int  commits = 0;

   vector_rf_wb_arbiter #(.VECTOR_SIZE(VS), .DATA_LEN(DL), .NUM_VREG(NV)) dut (
      .clk(clk), .rst(rst), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs3(issue_rs3), .issue_rd(issue_rd),
      .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
      .issue_use_rs3(issue_use_rs3), .issue_wr_rd(issue_wr_rd),
      .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready), .alu_wb_rd(alu_wb_rd),
      .alu_wb_data(alu_wb_data), .alu_wb_mask(alu_wb_mask), .alu_wb_vm(alu_wb_vm),
      .alu_wb_length(alu_wb_length), .alu_wb_dtype(alu_wb_dtype),
      .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready), .lsu_wb_rd(lsu_wb_rd),
      .lsu_wb_data(lsu_wb_data), .lsu_wb_mask(lsu_wb_mask), .lsu_wb_vm(lsu_wb_vm),
      .lsu_wb_length(lsu_wb_length), .lsu_wb_dtype(lsu_wb_dtype),
      .rf_signal(rf_signal), .rf_rd(rf_rd), .rf_data(rf_data), .rf_mask(rf_mask),
      .rf_vm(rf_vm), .rf_length(rf_length), .rf_dtype(rf_dtype), .rf_wb_en(rf_wb_en),
      .busy_vec(busy_vec), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic aV, input logic [4:0] aRd, input logic lV, input logic [4:0] lRd,
                                input logic iV, input logic [4:0] iRd, input logic iWr);
      alu_wb_valid = aV;
      alu_wb_rd    = aRd;
      lsu_wb_valid = lV;
      lsu_wb_rd    = lRd;
      for (int k = 0; k < VS; k++) begin
         alu_wb_data[k*DL +: DL] = $urandom();
         alu_wb_mask[k*DL +: DL] = $urandom();
         lsu_wb_data[k*DL +: DL] = $urandom();
         lsu_wb_mask[k*DL +: DL] = $urandom();
      end
      alu_wb_vm     = 1'($urandom_range(0, 1));
      lsu_wb_vm     = 1'($urandom_range(0, 1));
      alu_wb_length = DL'($urandom_range(0, VS));
      lsu_wb_length = DL'($urandom_range(0, VS));
      alu_wb_dtype  = 3'($urandom_range(ONE_BYTE, ONE_BIT));
      lsu_wb_dtype  = 3'($urandom_range(ONE_BYTE, ONE_BIT));
      issue_valid   = iV;
      issue_rd      = iRd;
      issue_wr_rd   = iWr;
      issue_rs1     = 5'd0;
      issue_rs2     = 5'd0;
      issue_rs3     = 5'd0;
      issue_use_rs1 = 1'b0;
      issue_use_rs2 = 1'b0;
      issue_use_rs3 = 1'b0;
   endtask

   function automatic hz_t mkHz(int r1, int r2, int r3, int rd, bit u1, bit u2, bit u3, bit wr, bit rdy, bit exp);
      hz_t h;
      h.rs1 = 5'(r1); h.rs2 = 5'(r2); h.rs3 = 5'(r3); h.rd = 5'(rd);
      h.u1 = u1; h.u2 = u2; h.u3 = u3; h.wr = wr; h.rdy = rdy; h.exp = exp;
      return h;
   endfunction

   // Expected writes are queued when a requester is accepted and checked when the RF commits.
   always @(negedge clk) begin
      if (rst && rdy_in && alu_wb_ready) begin
         sbPush.rd = alu_wb_rd; sbPush.data = alu_wb_data; sbPush.mask = alu_wb_mask;
         sbPush.vm = alu_wb_vm; sbPush.len = alu_wb_length; sbPush.dtype = alu_wb_dtype;
         sbq.push_back(sbPush);
      end
      if (rst && rdy_in && lsu_wb_ready) begin
         sbPush.rd = lsu_wb_rd; sbPush.data = lsu_wb_data; sbPush.mask = lsu_wb_mask;
         sbPush.vm = lsu_wb_vm; sbPush.len = lsu_wb_length; sbPush.dtype = lsu_wb_dtype;
         sbq.push_back(sbPush);
      end
      if (rst && rdy_in && rf_wb_en) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL sb_unexpected_write: got rd %0d expected no write", rf_rd);
         end else begin
            sbExp = sbq.pop_front();
            commits++;
            checkOutput("sb_rd", VW'(rf_rd), VW'(sbExp.rd));
            checkOutput("sb_data", rf_data, sbExp.data);
            checkOutput("sb_mask", rf_mask, sbExp.mask);
            checkOutput("sb_vm", VW'(rf_vm), VW'(sbExp.vm));
            checkOutput("sb_length", VW'(rf_length), VW'(sbExp.len));
            checkOutput("sb_dtype", VW'(rf_dtype), VW'(sbExp.dtype));
            checkOutput("sb_signal", VW'(rf_signal), VW'(VECTOR_RF_WRITE));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no completion expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      hz_t hz[10];
      bit  t3Alu[8]  = '{1, 0, 0, 0, 1, 0, 0, 0};
      bit  t3Lsu[8]  = '{0, 0, 1, 0, 0, 0, 1, 0};
      bit  t3IssV[8] = '{0, 1, 1, 1, 1, 0, 0, 0};
      int  t3IssRd[8] = '{0, 20, 1, 2, 2, 0, 0, 0};
      bit  t3IssRdy[8] = '{1, 1, 1, 0, 1, 1, 1, 1};

      // Hazard table, evaluated with registers 3 and 10 pending.
      hz[0] = mkHz(3, 0, 0, 0,   1, 0, 0, 0, 1, 0);
      hz[1] = mkHz(3, 4, 0, 0,   0, 1, 0, 0, 1, 1);
      hz[2] = mkHz(0, 10, 0, 0,  0, 1, 0, 0, 1, 0);
      hz[3] = mkHz(0, 0, 10, 0,  0, 0, 1, 0, 1, 0);
      hz[4] = mkHz(0, 0, 0, 3,   0, 0, 0, 1, 1, 0);
      hz[5] = mkHz(1, 0, 0, 3,   1, 0, 0, 0, 1, 1);
      hz[6] = mkHz(3, 10, 3, 10, 0, 0, 0, 0, 1, 1);
      hz[7] = mkHz(4, 5, 6, 7,   1, 1, 1, 1, 1, 1);
      hz[8] = mkHz(4, 5, 6, 7,   1, 1, 1, 1, 0, 0);
      hz[9] = mkHz(11, 0, 3, 10, 1, 0, 0, 0, 1, 1);

      rst = 1'b0;
      rdy_in = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      mid();
      checkOutput("rst_busy", VW'(busy_vec), '0);
      checkOutput("rst_wb_en", VW'(rf_wb_en), '0);
      checkOutput("rst_signal", VW'(rf_signal), VW'(RF_NOP));
      checkOutput("rst_err", VW'(wb_err), '0);
      checkOutput("rst_rf_data", rf_data, '0);
      checkOutput("rst_rf_rd", VW'(rf_rd), '0);
      cyc();
      rst = 1'b1;

      // Set up registers 3 and 10 as pending.
      cyc(); applyStimulus(0, 0, 0, 0, 1, 5'd3, 1);
      mid(); checkOutput("setup_issue3", VW'(issue_ready), VW'(1'b1));
      cyc(); applyStimulus(0, 0, 0, 0, 1, 5'd10, 1);
      mid(); checkOutput("setup_issue10", VW'(issue_ready), VW'(1'b1));

      for (int i = 0; i < 10; i++) begin
         cyc();
         applyStimulus(0, 0, 0, 0, 0, hz[i].rd, hz[i].wr);
         issue_rs1 = hz[i].rs1; issue_rs2 = hz[i].rs2; issue_rs3 = hz[i].rs3;
         issue_use_rs1 = hz[i].u1; issue_use_rs2 = hz[i].u2; issue_use_rs3 = hz[i].u3;
         rdy_in = hz[i].rdy;
         mid();
         checkOutput($sformatf("hazard_%0d", i), VW'(issue_ready), VW'(hz[i].exp));
      end
      cyc(); rdy_in = 1'b1; applyStimulus(0, 0, 0, 0, 0, 0, 0);
      mid(); checkOutput("busy_after_table", VW'(busy_vec), VW'(32'h0000_0408));

      // Both requesters contend; grants alternate starting with the ALU.
      cyc(); applyStimulus(0, 0, 0, 0, 1, 5'd1, 1);
      cyc(); applyStimulus(0, 0, 0, 0, 1, 5'd2, 1);
      for (int c = 0; c < 8; c++) begin
         cyc();
         applyStimulus(1, 5'd1, 1, 5'd2, t3IssV[c], 5'(t3IssRd[c]), t3IssV[c]);
         mid();
         checkOutput($sformatf("rr_alu_ready_%0d", c), VW'(alu_wb_ready), VW'(t3Alu[c]));
         checkOutput($sformatf("rr_lsu_ready_%0d", c), VW'(lsu_wb_ready), VW'(t3Lsu[c]));
         checkOutput($sformatf("rr_issue_ready_%0d", c), VW'(issue_ready), VW'(t3IssRdy[c]));
      end
      cyc(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
      mid();
      checkOutput("busy_after_rr", VW'(busy_vec), VW'(32'h0010_0408));
      checkOutput("err_after_rr", VW'(wb_err), '0);

      // RAW on register 3 stalls until the cycle after its write commits.
      cyc(); applyStimulus(1, 5'd3, 0, 0, 1, 0, 0);
      issue_use_rs1 = 1'b1; issue_rs1 = 5'd3;
      mid();
      checkOutput("raw_alu_ready", VW'(alu_wb_ready), VW'(1'b1));
      checkOutput("raw_stall_0", VW'(issue_ready), '0);
      cyc(); alu_wb_valid = 1'b0;
      mid();
      checkOutput("raw_wb_en", VW'(rf_wb_en), VW'(1'b1));
      checkOutput("raw_rf_rd", VW'(rf_rd), VW'(5'd3));
      checkOutput("raw_stall_1", VW'(issue_ready), '0);
      cyc();
      mid();
      checkOutput("raw_wb_en_drop", VW'(rf_wb_en), '0);
      checkOutput("raw_signal_nop", VW'(rf_signal), VW'(RF_NOP));
      checkOutput("raw_released", VW'(issue_ready), VW'(1'b1));

      // LSU alone is granted at every IDLE.
      cyc(); applyStimulus(0, 0, 0, 0, 1, 5'd21, 1);
      cyc(); applyStimulus(0, 0, 0, 0, 1, 5'd22, 1);
      for (int c = 0; c < 6; c++) begin
         cyc();
         applyStimulus(0, 0, 1, 5'(20 + c / 2), 0, 0, 0);
         mid();
         checkOutput($sformatf("lsu_only_ready_%0d", c), VW'(lsu_wb_ready), VW'((c % 2) == 0));
         checkOutput($sformatf("lsu_only_alu_%0d", c), VW'(alu_wb_ready), '0);
      end
      cyc(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
      mid(); checkOutput("busy_after_lsu", VW'(busy_vec), VW'(32'h0000_0400));

      // Write-back to a register that was never issued.
      cyc(); applyStimulus(0, 0, 1, 5'd7, 0, 0, 0);
      mid();
      checkOutput("err_lsu_ready", VW'(lsu_wb_ready), VW'(1'b1));
      checkOutput("err_before", VW'(wb_err), '0);
      cyc(); lsu_wb_valid = 1'b0;
      mid();
      checkOutput("err_wb_en", VW'(rf_wb_en), VW'(1'b1));
      checkOutput("err_during_write", VW'(wb_err), '0);
      cyc();
      mid(); checkOutput("err_set", VW'(wb_err), VW'(1'b1));
      cyc(); cyc();
      mid();
      checkOutput("err_sticky", VW'(wb_err), VW'(1'b1));
      checkOutput("err_busy", VW'(busy_vec), VW'(32'h0000_0400));

      // Freeze with rdy_in low while a write is in flight.
      cyc(); applyStimulus(0, 0, 0, 0, 1, 5'd12, 1);
      mid(); checkOutput("frz_issue12", VW'(issue_ready), VW'(1'b1));
      cyc(); applyStimulus(1, 5'd12, 0, 0, 0, 0, 0);
      mid(); checkOutput("frz_alu_ready", VW'(alu_wb_ready), VW'(1'b1));
      for (int k = 0; k < 3; k++) begin
         cyc();
         rdy_in = 1'b0; alu_wb_valid = 1'b1; lsu_wb_valid = 1'b1;
         mid();
         checkOutput($sformatf("frz_wb_en_%0d", k), VW'(rf_wb_en), VW'(1'b1));
         checkOutput($sformatf("frz_rf_rd_%0d", k), VW'(rf_rd), VW'(5'd12));
         checkOutput($sformatf("frz_alu_%0d", k), VW'(alu_wb_ready), '0);
         checkOutput($sformatf("frz_lsu_%0d", k), VW'(lsu_wb_ready), '0);
         checkOutput($sformatf("frz_busy_%0d", k), VW'(busy_vec), VW'(32'h0000_1400));
      end
      cyc(); rdy_in = 1'b1; alu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
      mid(); checkOutput("frz_resume_wb_en", VW'(rf_wb_en), VW'(1'b1));
      cyc();
      mid();
      checkOutput("frz_done_wb_en", VW'(rf_wb_en), '0);
      checkOutput("frz_done_busy", VW'(busy_vec), VW'(32'h0000_0400));

      // Asynchronous reset in the middle of a write drops it.
      cyc(); applyStimulus(0, 0, 0, 0, 1, 5'd5, 1);
      cyc(); applyStimulus(1, 5'd5, 0, 0, 0, 0, 0);
      mid(); checkOutput("rstw_alu_ready", VW'(alu_wb_ready), VW'(1'b1));
      cyc(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("rstw_in_write", VW'(rf_wb_en), VW'(1'b1));
      rst = 1'b0;
      #1;
      checkOutput("rstw_wb_en", VW'(rf_wb_en), '0);
      checkOutput("rstw_busy", VW'(busy_vec), '0);
      checkOutput("rstw_err", VW'(wb_err), '0);
      checkOutput("rstw_signal", VW'(rf_signal), VW'(RF_NOP));
      checkOutput("rstw_pending", VW'(sbq.size()), VW'(1));
      sbq.delete();
      cyc(); rst = 1'b1;
      cyc(); cyc();
      mid();
      checkOutput("rstw_after_wb_en", VW'(rf_wb_en), '0);
      checkOutput("rstw_after_err", VW'(wb_err), '0);
      checkOutput("commit_count", VW'(commits), VW'(10));
      checkOutput("sb_empty", VW'(sbq.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
